e_muldiv_unit: RTL
==================

Name: e_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the E stage. It is the sequential companion to the combinational E-stage ALU.
- Executes mult/multu/div/divu with configurable latency. Also executes single-cycle mthi/mtlo.
- Holds architectural HI/LO registers.
- Exposes busy for the hazard unit (stall rule: busy | start).
- Honours an exception/interrupt request so a flushed instruction never starts.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start  input  1  E-stage instruction is an MDU op this cycle
- MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  input  WIDTH  rs operand
- B  input  WIDTH  rt operand
- req  input  1  exception/interrupt flush in this cycle
- busy  output  1  multi-cycle op in progress
- HI  output  WIDTH  HI register
- LO  output  WIDTH  LO register

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset); it is sampled on the rising edge of clk.
- Reset values: busy=0, HI=0, LO=0, counter=0, pending result=0.
- Reset mid-operation: the operation is abandoned; no commit occurs.
- States: IDLE and RUN.
  - Accept condition: start & ~req & ~busy & (MDUOp in 1..6).
  - IDLE, accept of op 1-4: latch the pending {hi,lo} result (computed from A/B at accept) and load counter with the op's latency. Go to RUN; busy=1 from the next cycle.
  - IDLE, accept of op 5/6 (mthi/mtlo): HI<=A or LO<=A at the same edge. Stay in IDLE; busy stays 0.
  - RUN: counter decrements each edge. On the edge where counter==1, commit {HI,LO}<=pending, set busy<=0, and return to IDLE.
- Latency: an op accepted at edge t has busy high for exactly N cycles (N=MUL_CYCLES or DIV_CYCLES). New HI/LO are visible after edge t+N, the same edge busy falls.
- HI/LO hold their old values throughout RUN.
- Ignored starts: start while busy is ignored (the hazard unit guarantees this via stall). start with req=1 is ignored (flushed instruction).
- req during RUN does not cancel; the in-flight op completes and commits.
- Arithmetic:
  - mult: signed 2W-bit product; HI=upper W bits, LO=lower W bits.
  - multu: same, unsigned.
  - div: LO=signed quotient truncated toward zero; HI=remainder, taking the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Boundaries:
  - Divide by zero (B==0): op runs full DIV_CYCLES with busy; HI/LO are left unchanged at commit.
  - Signed overflow (A=MIN, B=-1): LO=MIN, HI=0; no exception is raised.
- Back-to-back: a start in the cycle after busy falls is accepted normally.
- mthi/mtlo in the cycle busy falls is a start while busy and is ignored; the stall prevents this.

Test Plan:
- Reset, then mult A=0xFFFFFFFF(-1), B=2 -> busy high cycles 1-5; after edge 5 HI=0xFFFFFFFF, LO=0xFFFFFFFE; busy=0.
- multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles. HI/LO keep previous values while busy.
- div A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu A=7, B=2 -> LO=3, HI=1.
- divu A=5, B=0 with prior HI=0x11, LO=0x22 -> busy 10 cycles, HI=0x11, LO=0x22 unchanged. div A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
- start mult with req=1 -> busy stays 0, HI/LO unchanged. Start div, then raise req in cycle 3 -> op still commits at cycle 10. start mult during RUN -> ignored.
- mthi A=0x1234 -> HI=0x1234 next edge, busy 0. Assert reset in cycle 3 of a div -> busy=0, HI=LO=0 next edge, no later commit.

Source files
------------

// File: rtl/e_muldiv_unit.sv
// E-stage multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed from A/B at accept time and held as a pending value.
// It is committed to HI/LO when the latency counter expires.
module e_muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             req,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [0:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] pending;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               accept;
  logic               is_mul;
  logic [2*WIDTH-1:0] result;
  logic [2*WIDTH-1:0] a_sext, b_sext, a_zext, b_zext;
  logic [2*WIDTH-1:0] smul, umul;
  logic signed [WIDTH-1:0] squot, srem;
  logic [WIDTH-1:0]   uquot, urem;
  logic               div_zero, div_ovf;

  assign busy = (state == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

  assign accept = start & ~req & (state == S_IDLE) & (MDUOp != 3'd0) & (MDUOp != 3'd7);
  assign is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);

  // Operands are explicitly extended to 2W so the full product is formed.
  assign a_sext = {{WIDTH{A[WIDTH-1]}}, A};
  assign b_sext = {{WIDTH{B[WIDTH-1]}}, B};
  assign a_zext = {{WIDTH{1'b0}}, A};
  assign b_zext = {{WIDTH{1'b0}}, B};
  assign smul   = a_sext * b_sext;
  assign umul   = a_zext * b_zext;

  assign squot    = $signed(A) / $signed(B);
  assign srem     = $signed(A) % $signed(B);
  assign uquot    = A / B;
  assign urem     = A % B;
  assign div_zero = (B == '0);
  assign div_ovf  = (A == SMIN) && (B == '1);

  // Select the {hi,lo} value to commit at the end of the operation.
  // Divide by zero re-commits the current HI/LO, leaving them unchanged.
  always_comb begin
    result = {hi_q, lo_q};
    case (MDUOp)
      OP_MULT:  result = smul;
      OP_MULTU: result = umul;
      OP_DIV: begin
        if (div_zero)     result = {hi_q, lo_q};
        else if (div_ovf) result = {{WIDTH{1'b0}}, SMIN};
        else              result = {srem, squot};
      end
      OP_DIVU: begin
        if (!div_zero) result = {urem, uquot};
      end
      default: result = {hi_q, lo_q};
    endcase
  end

  // IDLE/RUN control, latency counter and HI/LO update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pending <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (MDUOp == OP_MTHI) begin
              hi_q <= A;
            end else if (MDUOp == OP_MTLO) begin
              lo_q <= A;
            end else begin
              pending <= result;
              cnt     <= is_mul ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
              state   <= S_RUN;
            end
          end
        end
        default: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            hi_q  <= pending[2*WIDTH-1:WIDTH];
            lo_q  <= pending[WIDTH-1:0];
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
